// File: rtl/deframe_pkg.sv
// Shared types and constants for the serial frame deframer.
// Holds the capture state enum and the byte width.
package deframe_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PAYLOAD = 1'b1
   } state_t;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/frame_deframer_if.sv
// Byte output stream of the deframer (valid/ready plus last marker).
// master: dout, dout_valid, dout_last out; dout_ready in. slave: mirror.
interface frame_deframer_if;
   import deframe_pkg::*;

   logic [BYTE_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              dout_last;

   modport master (
      output dout,
      output dout_valid,
      output dout_last,
      input  dout_ready
   );

   modport slave (
      input  dout,
      input  dout_valid,
      input  dout_last,
      output dout_ready
   );

endinterface

// File: rtl/deframe_out_reg.sv
// Single-entry output holding register with valid/ready handshake.
// Ports: clk, rst, push/push_data/push_last in, dout_ready in;
// dout, dout_valid, dout_last, overflow (1-cycle pulse) out.
module deframe_out_reg
   import deframe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [BYTE_W-1:0] push_data,
   input  logic              push_last,
   input  logic              dout_ready,
   output logic [BYTE_W-1:0] dout,
   output logic              dout_valid,
   output logic              dout_last,
   output logic              overflow
);

   logic accept;

   assign accept = dout_valid & dout_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (push && dout_valid && !dout_ready) begin
            // held byte still pending: new byte is lost
            overflow <= 1'b1;
         end else if (push) begin
            dout       <= push_data;
            dout_valid <= 1'b1;
            dout_last  <= push_last;
         end else if (accept) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/frame_deframer.sv
// Captures PAYLOAD_BYTES bytes MSB-first after a sync-flag rising edge.
// Ports: clk, rst, din, flag in; out_if (byte stream master);
// frame_abort (resync pulse) and overflow (dropped byte pulse) out.
module frame_deframer
   import deframe_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 4,
   parameter bit RESYNC_EN     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              flag,
   frame_deframer_if.master  out_if,
   output logic              frame_abort,
   output logic              overflow
);

   localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

   state_t            state;
   logic              flag_q;
   logic [2:0]        bit_cnt;
   logic [7:0]        byte_cnt;
   logic [BYTE_W-2:0] shreg;

   logic              sync_hit;
   logic              byte_done;
   logic              last_byte;
   logic              resync;
   logic              start;
   logic              push;
   logic [BYTE_W-1:0] push_data;

   always_comb begin
      sync_hit  = flag & ~flag_q;
      byte_done = (state == PAYLOAD) && (bit_cnt == 3'd7);
      last_byte = byte_done && (byte_cnt == LAST_IDX);
      // a sync on the final bit closes the frame cleanly instead
      resync    = RESYNC_EN && (state == PAYLOAD)
                  && sync_hit && !last_byte;
      start     = sync_hit
                  && ((state == IDLE) || resync || last_byte);
      push      = byte_done && !resync;
      push_data = {shreg, din};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         flag_q      <= 1'b0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         shreg       <= '0;
         frame_abort <= 1'b0;
      end else begin
         flag_q      <= flag;
         frame_abort <= 1'b0;
         if (start) begin
            state       <= PAYLOAD;
            shreg       <= {{(BYTE_W-2){1'b0}}, din};
            bit_cnt     <= 3'd1;
            byte_cnt    <= '0;
            frame_abort <= resync;
         end else if (state == PAYLOAD) begin
            shreg   <= {shreg[BYTE_W-3:0], din};
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
               byte_cnt <= byte_cnt + 8'd1;
               if (last_byte) begin
                  state <= IDLE;
               end
            end
         end
      end
   end

   deframe_out_reg u_out (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  (push_data),
      .push_last  (last_byte),
      .dout_ready (out_if.dout_ready),
      .dout       (out_if.dout),
      .dout_valid (out_if.dout_valid),
      .dout_last  (out_if.dout_last),
      .overflow   (overflow)
   );

endmodule

// File: doc/frame_deframer.md
FRAME_DEFRAMER -- requirements
Module: frame_deframer

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 4: number of payload bytes captured per frame (legal range 1..255).
REQ-002 SHALL have parameter RESYNC_EN, default 1: 1 = a new sync aborts an in-progress frame; 0 = sync is ignored while a frame is in progress.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  1  serial bit stream, the same stream fed to the sync detector.
REQ-006 SHALL have port flag  input  1  sync-detector flag for "00111100"; high for 2 cycles; the cycle of its rising edge carries payload bit 0 on din.
REQ-007 SHALL have port dout  output  8  assembled payload byte, MSB = first received bit.
REQ-008 SHALL have port dout_valid  output  1  dout holds an unaccepted byte.
REQ-009 SHALL have port dout_ready  input  1  downstream accepts dout when dout_valid & dout_ready.
REQ-010 SHALL have port dout_last  output  1  qualifies dout as the final byte of a frame; valid only with dout_valid.
REQ-011 SHALL have port frame_abort  output  1  one-cycle pulse when a frame in progress is discarded by resync.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse when a completed byte is dropped for lack of space.

Function
REQ-013 SHALL register flag each cycle and define sync_hit = flag & ~flag_q; only the rising edge counts, and the second flag cycle is ignored.
REQ-014 SHALL implement states IDLE and PAYLOAD.
REQ-015 In IDLE, SHALL ignore din; on sync_hit, SHALL go to PAYLOAD and sample that cycle's din as bit 7 of byte 0.
REQ-016 In PAYLOAD, SHALL shift din in MSB-first each cycle, using a 3-bit bit counter and an 8-bit byte counter.
REQ-017 On the edge sampling the 8th bit of a byte, SHALL present that byte on dout with dout_valid=1 in the next cycle (latency 1 cycle from the 8th bit on din).
REQ-018 On completion of byte PAYLOAD_BYTES-1, SHALL set dout_last=1 with that byte and return to IDLE on the same edge.
REQ-019 SHALL hold dout, dout_valid and dout_last stable while dout_valid & ~dout_ready.
REQ-020 If a byte completes while dout_valid=1 and dout_ready=0, SHALL drop the new byte, keep the held byte, and pulse overflow; the frame continues and the byte counter still advances.
REQ-021 If a byte completes in the same cycle as dout_valid & dout_ready, SHALL load the new byte and keep dout_valid=1 with no overflow.
REQ-022 With RESYNC_EN=1, on sync_hit in PAYLOAD, SHALL pulse frame_abort, discard the partial byte, reset the counters and restart at bit 7 of byte 0 with the current din.
REQ-023 Resync (REQ-022) SHALL take priority over simultaneous byte completion, and the completing byte SHALL be discarded.
REQ-024 Resync SHALL leave an already-held output byte untouched.
REQ-025 With RESYNC_EN=0, SHALL ignore sync_hit in PAYLOAD.
REQ-026 sync_hit on the same edge that returns the block to IDLE (last byte, REQ-018) SHALL start a new frame with no frame_abort.

Reset
REQ-027 While rst=1, SHALL force state=IDLE, clear both counters and flag_q, and drive dout=8'h00, dout_valid=0, dout_last=0, frame_abort=0, overflow=0.
REQ-028 Reset mid-frame SHALL discard all partial and held data; the block SHALL capture nothing until a fresh sync_hit after rst deasserts.

Structure
REQ-029 Shared package deframe_pkg SHALL hold the state enum (IDLE, PAYLOAD) and constant BYTE_W=8.
REQ-030 The output holding register SHALL be the sub-module deframe_out_reg, covering dout, dout_valid, dout_last, the valid/ready handshake and overflow detection.

Verification
REQ-031 Reset: rst=1 for 3 cycles with random din/flag -> all outputs 0 and no dout_valid.
REQ-032 Clean frame, PAYLOAD_BYTES=4, dout_ready=1: 2-cycle flag pulse, then din=A5,0F,F0,81 MSB-first -> four single-cycle dout_valid beats A5,0F,F0,81; dout_last only on 81; no overflow or frame_abort.
REQ-033 Backpressure: same frame with dout_ready=0 -> dout=A5 held valid; overflow pulses at completion of 0F, F0 and 81; dout_last stays 0; raising dout_ready afterwards accepts A5 once.
REQ-034 Resync, RESYNC_EN=1: new flag rising edge after 13 payload bits, then bytes 11,22,33,44 -> frame_abort pulses once; dout beats A5 then 11,22,33,44, with last on 44.
REQ-035 RESYNC_EN=0: flag pulse injected at payload bit 13 of A5,0F,F0,81 -> frame_abort stays 0 and all four bytes are delivered unchanged.
REQ-036 Reset mid-frame: rst=1 for 1 cycle during bit 5 of byte 2 -> outputs clear; subsequent din without flag produces no dout_valid; next sync captures normally.
